// File: rtl/multicycle_alu_pkg.sv
// Shared command codes, status bit positions and FSM state type for the
// multi-cycle execute-stage ALU.
package multicycle_alu_pkg;

  localparam int LEN_EXECUTE_COMMAND = 4;
  localparam int LEN_STATUS          = 4;

  localparam int STAT_N = 3;
  localparam int STAT_Z = 2;
  localparam int STAT_C = 1;
  localparam int STAT_V = 0;

  // Code 4'hF is left unassigned and yields a zero result.
  typedef enum logic [LEN_EXECUTE_COMMAND-1:0] {
    EXE_MOV  = 4'h0,
    EXE_MVN  = 4'h1,
    EXE_ADD  = 4'h2,
    EXE_ADC  = 4'h3,
    EXE_SUB  = 4'h4,
    EXE_SBC  = 4'h5,
    EXE_AND  = 4'h6,
    EXE_ORR  = 4'h7,
    EXE_EOR  = 4'h8,
    EXE_CMP  = 4'h9,
    EXE_TST  = 4'hA,
    EXE_LDR  = 4'hB,
    EXE_STR  = 4'hC,
    EXE_MUL  = 4'hD,
    EXE_UDIV = 4'hE
  } exe_cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_seq_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// cycle; done flags the cycle whose step produces the final value on res.
module seq_muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_mode;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;

  // For division a_sh shifts the dividend out at the top and quotient bits in at the bottom.
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    done    = run && (cnt_nxt == CNT_LAST);
    rem_sh  = {rem, a_sh[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_sh};
    a_nxt   = a_sh;
    b_nxt   = b_sh;
    acc_nxt = acc;
    rem_nxt = rem;
    if (div_mode) begin
      rem_nxt = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
      a_nxt   = {a_sh[WIDTH-2:0], ~rem_sub[WIDTH]};
    end else begin
      if (b_sh[0]) acc_nxt = acc + a_sh;
      a_nxt = {a_sh[WIDTH-2:0], 1'b0};
      b_nxt = {1'b0, b_sh[WIDTH-1:1]};
    end
    res = div_mode ? a_nxt : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      div_mode <= is_div;
      a_sh     <= a;
      b_sh     <= b;
      acc      <= '0;
      rem      <= '0;
    end else if (run) begin
      a_sh <= a_nxt;
      b_sh <= b_nxt;
      acc  <= acc_nxt;
      rem  <= rem_nxt;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU: registered single-cycle ops plus WIDTH-cycle
// unsigned multiply and divide through seq_muldiv_core.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LEN_EXECUTE_COMMAND-1:0] command,
  input  logic [WIDTH-1:0]               op1,
  input  logic [WIDTH-1:0]               op2,
  input  logic [LEN_STATUS-1:0]          status_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               result,
  output logic [LEN_STATUS-1:0]          status_bits,
  output logic                           busy
);

  function automatic logic [WIDTH+LEN_STATUS-1:0] alu_exec(
    input logic [LEN_EXECUTE_COMMAND-1:0] cmd,
    input logic [WIDTH-1:0]               a,
    input logic [WIDTH-1:0]               b,
    input logic                           cin
  );
    logic [WIDTH:0]          ext;
    logic                    chk_add;
    logic                    chk_sub;
    logic                    v;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] sr;
    logic [LEN_STATUS-1:0]   st;
    ext     = '0;
    chk_add = 1'b0;
    chk_sub = 1'b0;
    case (cmd)
      EXE_MOV:          ext = {1'b0, b};
      EXE_MVN:          ext = {1'b0, ~b};
      EXE_ADD: begin
        ext     = {1'b0, a} + {1'b0, b};
        chk_add = 1'b1;
      end
      EXE_LDR, EXE_STR: ext = {1'b0, a} + {1'b0, b};
      EXE_ADC: begin
        ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        chk_add = 1'b1;
      end
      EXE_SUB, EXE_CMP: begin
        ext     = {1'b0, a} - {1'b0, b};
        chk_sub = 1'b1;
      end
      EXE_SBC: begin
        ext     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ~cin};
        chk_sub = 1'b1;
      end
      EXE_AND, EXE_TST: ext = {1'b0, a & b};
      EXE_ORR:          ext = {1'b0, a | b};
      EXE_EOR:          ext = {1'b0, a ^ b};
      default:          ext = '0;
    endcase
    sa = a;
    sb = b;
    sr = ext[WIDTH-1:0];
    v  = 1'b0;
    if (chk_add) v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    if (chk_sub) v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    st         = '0;
    st[STAT_N] = ext[WIDTH-1];
    st[STAT_Z] = (ext[WIDTH-1:0] == '0);
    st[STAT_C] = ext[WIDTH];
    st[STAT_V] = v;
    return {ext[WIDTH-1:0], st};
  endfunction

  alu_state_e                    state;
  alu_state_e                    state_nxt;
  logic                          accept;
  logic                          is_multi;
  logic                          is_div;
  logic [WIDTH+LEN_STATUS-1:0]   alu_out;
  logic [WIDTH-1:0]              alu_res;
  logic [LEN_STATUS-1:0]         alu_st;
  logic                          core_done;
  logic [WIDTH-1:0]              core_res;
  logic [LEN_STATUS-1:0]         core_st;
  logic [1:0]                    cv_p0;
  logic                          stat_unused;

  assign stat_unused = status_in[STAT_N] ^ status_in[STAT_Z];

  assign is_div    = (command == EXE_UDIV);
  assign is_multi  = (command == EXE_MUL) || (is_div && (op2 != '0));
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);

  // Divide by zero finishes here with a zero quotient; C and V pass through.
  always_comb begin
    alu_out = alu_exec(command, op1, op2, status_in[STAT_C]);
    alu_res = alu_out[WIDTH+LEN_STATUS-1:LEN_STATUS];
    alu_st  = alu_out[LEN_STATUS-1:0];
    if (is_div) begin
      alu_st[STAT_C] = status_in[STAT_C];
      alu_st[STAT_V] = status_in[STAT_V];
    end
  end

  always_comb begin
    core_st         = '0;
    core_st[STAT_N] = core_res[WIDTH-1];
    core_st[STAT_Z] = (core_res == '0);
    core_st[STAT_C] = cv_p0[1];
    core_st[STAT_V] = cv_p0[0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_multi ? S_BUSY : S_DONE;
      S_BUSY: if (core_done) state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = is_multi ? S_BUSY : S_DONE;
          else          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      result      <= '0;
      status_bits <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !is_multi) begin
        result      <= alu_res;
        status_bits <= alu_st;
      end else if (core_done) begin
        result      <= core_res;
        status_bits <= core_st;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) cv_p0 <= {status_in[STAT_C], status_in[STAT_V]};
  end

  seq_muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_multi),
    .is_div (is_div),
    .a      (op1),
    .b      (op2),
    .done   (core_done),
    .res    (core_res)
  );

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked successor to the execute-stage ALU. It performs the full `EXE_*` command set with a registered 1-cycle latency, and adds iterative unsigned multiply (`EXE_MUL`) and unsigned divide (`EXE_UDIV`) that take WIDTH cycles. It sits in the EXE stage between the ID/EXE pipeline register and the EXE/MEM register. The pipeline stalls on `in_ready`/`out_valid`.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept; transfer when in_valid & in_ready
- command  input  `LEN_EXECUTE_COMMAND`  `EXE_*` code
- op1, op2  input  WIDTH  operands (op1 dividend/multiplicand)
- status_in  input  `LEN_STATUS`  {N,Z,C,V}; C is the carry-in
- out_valid  output  1  result/status valid, held until out_ready
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- status_bits  output  `LEN_STATUS`  registered {N,Z,C,V}
- busy  output  1  high in BUSY state

## Operation
- Operands, command and `status_in` are captured on acceptance. Later changes on the inputs are ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE → DONE on accepting a single-cycle op, or `EXE_UDIV` with op2==0.
- IDLE → BUSY on accepting MUL, or UDIV with op2≠0.
- BUSY → DONE when the iteration counter reaches WIDTH.
- DONE → IDLE on out_ready & !in_valid.
- DONE → DONE or BUSY on out_ready & in_valid, which accepts a new op in the same cycle.
- `in_ready` = !rst & (IDLE | (DONE & out_ready)).
- `out_valid` = DONE.
- Single-cycle ops: compute in (WIDTH+1) bits. C is bit WIDTH.
  - MOV=op2; MVN=~op2.
  - ADD, LDR, STR = op1+op2; ADC = op1+op2+cin.
  - SUB, CMP = op1−op2; SBC = op1−op2−!cin.
  - AND, TST = &; ORR = |; EOR = ^.
  - Undefined codes give 0.
- N = result[WIDTH−1]. Z = (result==0).
- C is bit WIDTH of the extended result for all non-mul/div ops. For logic ops this gives C=0.
- V:
  - ADD, ADC: signed add overflow.
  - SUB, SBC, CMP: signed subtract overflow.
  - Otherwise 0.
  - Change from the previous ALU: CMP now produces V.
- MUL: shift-add, one bit per cycle. Result = low WIDTH bits of op1×op2. N, Z from the result; C, V pass through from the captured status_in.
- UDIV: restoring division, one quotient bit per cycle. Result = quotient; C, V pass through.
- UDIV with op2==0: result 0, N=0, Z=1, C and V pass through, 1-cycle latency.
- `EXE_MUL` and `EXE_UDIV` are two new codes in ISA.v. They are distinct from every existing `EXE_*` code, and `LEN_EXECUTE_COMMAND` is unchanged.

## Timing
- Reset (synchronous, takes effect at clk edge with rst=1):
  - state=IDLE, counter=0.
  - result=0, status_bits=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high.
- Single-cycle op accepted at edge k: out_valid=1 after edge k+1.
- MUL/UDIV accepted at edge k: busy=1 over edges k+1…k+WIDTH; out_valid=1 after edge k+WIDTH+1.
- Throughput:
  - Single-cycle ops: 1 per cycle while out_ready=1.
  - Multi-cycle ops: 1 per WIDTH+1 cycles.
- Backpressure: with out_ready=0 in DONE, result and status_bits stay stable and no new op is accepted.
- Reset mid-BUSY or mid-DONE aborts the op: no out_valid and no partial result is visible.
- Counter rolls to 0 on leaving BUSY. It never exceeds WIDTH.

## Structure
- ISA.v gains `EXE_MUL` and `EXE_UDIV`. `LEN_STATUS` is reused, and the status bit index order {N=3, Z=2, C=1, V=0} is added as shared defines.
- Sub-module `seq_muldiv_core`:
  - Holds the counter, accumulator/remainder and shift registers for MUL and UDIV.
  - Ports: start, is_div, a, b, done, product/quotient.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset then ADD: WIDTH=32, op1=0x7FFFFFFF, op2=1 → one cycle later result=0x80000000, status {N,Z,C,V}=1001, out_valid=1.
- Back-to-back with out_ready=1:
  - SUB 5−7 then CMP 0x80000000−1 on consecutive cycles.
  - Expected: SUB gives result 0xFFFFFFFE with N=1, C=1; CMP gives V=1.
  - One result per cycle.
- MUL 0x12345×0x100, status_in C=1,V=1 → out_valid exactly 33 cycles after accept, result=0x01234500, status 0011, busy high for 32 cycles.
- UDIV 100/7 → result 14 after 33 cycles; UDIV 5/0 → result 0, Z=1, 1 cycle.
- Backpressure:
  - out_ready=0 for 10 cycles in DONE → result stable, in_ready=0.
  - out_ready=1 with in_valid=1 accepts the next op in the same cycle.
- rst asserted at cycle 10 of a MUL → next cycle IDLE, out_valid=0. A new ADC 1+1 with cin=1 gives 3.
